// File: rtl/moore_1010_over.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : moore_1010_over                                            |
// | Description : Moore detector for serial pattern 1-0-1-0 with overlapping |
// |               matches; optional saturating match counter behind the      |
// |               MATCH_COUNT_EN macro.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module moore_1010_over #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c,
  output logic               d
`ifdef MATCH_COUNT_EN
  ,
  output logic [COUNT_W-1:0] match_cnt
`endif
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t r_state;
  logic   r_d;
  state_t w_next;

  // S4 on a 1 keeps the trailing "10" and resumes at "101".
  function automatic state_t f_next(input state_t s, input logic b);
    case (s)
      S0:      f_next = b ? S1 : S0;
      S1:      f_next = b ? S1 : S2;
      S2:      f_next = b ? S3 : S0;
      S3:      f_next = b ? S1 : S4;
      S4:      f_next = b ? S3 : S0;
      default: f_next = S0;
    endcase
  endfunction

  assign w_next = f_next(r_state, c);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S0;
      r_d     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_d     <= (w_next == S4);
    end
  end

  assign d = r_d;

`ifdef MATCH_COUNT_EN
  localparam logic [COUNT_W-1:0] c_CNT_MAX = {COUNT_W{1'b1}};

  logic [COUNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if ((w_next == S4) && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_moore_1010_over.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_moore_1010_over                                         |
// | Description : Self-checking bench for moore_1010_over; directed pattern  |
// |               tests plus randomized stream against a suffix model.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_moore_1010_over;

`ifdef MATCH_COUNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic          clk;
  logic          reset;
  logic          c;
  logic          d;
`ifdef MATCH_COUNT_EN
  logic [CW-1:0] match_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference: last four bits seen since reset and how many bits were seen.
  logic [3:0] m_hist;
  int         m_nbits;
  logic       m_d;
  int         m_cnt;

  moore_1010_over #(.COUNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .c        (c),
    .d        (d)
`ifdef MATCH_COUNT_EN
    ,
    .match_cnt(match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic cin);
    @(negedge clk);
    reset = rst;
    c     = cin;
    @(posedge clk);
    if (rst) begin
      m_hist  = 4'b0000;
      m_nbits = 0;
      m_d     = 1'b0;
      m_cnt   = 0;
    end else begin
      m_hist  = {m_hist[2:0], cin};
      m_nbits = m_nbits + 1;
      m_d     = (m_nbits >= 4) && (m_hist == 4'b1010);
      if (m_d && m_cnt < (2**CW - 1)) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    checks++;
    if (d !== 1'b0) begin
      errors++;
      $display("FAIL reset_d: got %b want 0", d);
    end
`ifdef MATCH_COUNT_EN
    checks++;
    if (match_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", match_cnt);
    end
`endif
    // c=1 during reset must be ignored, so 0,1,0 afterwards is not a match.
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if (d !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_c: got %b want 0", d);
    end
  endtask

  // Applies bit string pat (MSB first, n bits) after a reset, checking d each edge.
  task automatic run_pattern(input string name, input logic [15:0] pat,
                             input logic [15:0] exp, input int n);
    step(1'b1, 1'b0);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, pat[i]);
      checks++;
      if (d !== exp[i]) begin
        errors++;
        $display("FAIL %s edge %0d: got d=%b want %b", name, n - i, d, exp[i]);
      end
    end
  endtask

  task automatic test_basic();
    run_pattern("basic_1010", 16'b1010, 16'b0001, 4);
  endtask

  task automatic test_back_to_back();
    run_pattern("overlap_101010", 16'b101010, 16'b000101, 6);
  endtask

  task automatic test_variants();
    run_pattern("lead1_11010", 16'b11010, 16'b00001, 5);
    run_pattern("nomatch_10010", 16'b10010, 16'b00000, 5);
  endtask

  task automatic test_reset_partial();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (d !== 1'b0) begin
      errors++;
      $display("FAIL reset_partial: got %b want 0", d);
    end
  endtask

  task automatic test_reset_in_s4();
    for (int k = 0; k < 2; k++) begin
      run_pattern("reach_s4", 16'b1010, 16'b0001, 4);
      step(1'b1, k[0]);
      checks++;
      if (d !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_s4 c=%0d: got %b want 0", k, d);
      end
    end
  endtask

`ifdef MATCH_COUNT_EN
  task automatic test_count_sat();
    logic [13:0] s;
    int exp_cnt;
    s = 14'b10101010101010;
    exp_cnt = 0;
    step(1'b1, 1'b0);
    for (int i = 13; i >= 0; i--) begin
      step(1'b0, s[i]);
      if (i <= 10 && i[0] == 1'b0 && exp_cnt < 3) exp_cnt++;
      checks++;
      if (match_cnt !== exp_cnt[CW-1:0]) begin
        errors++;
        $display("FAIL count_sat edge %0d: got %0d want %0d", 14 - i, match_cnt, exp_cnt);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic rb;
    logic cb;
    step(1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      rb = ($urandom_range(0, 39) == 0);
      cb = ($urandom_range(0, 99) < 55);
      step(rb, cb);
      checks++;
      if (d !== m_d) begin
        errors++;
        $display("FAIL random_d cycle %0d: got %b want %b", i, d, m_d);
      end
`ifdef MATCH_COUNT_EN
      checks++;
      if (match_cnt !== m_cnt[CW-1:0]) begin
        errors++;
        $display("FAIL random_cnt cycle %0d: got %0d want %0d", i, match_cnt, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    reset   = 1'b1;
    c       = 1'b0;
    m_hist  = 4'b0000;
    m_nbits = 0;
    m_d     = 1'b0;
    m_cnt   = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_variants();
    test_reset_partial();
    test_reset_in_s4();
`ifdef MATCH_COUNT_EN
    test_count_sat();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
